pwm_multi: RTL and testbench

- Parametrised N-channel PWM generator for motor ESC/servo outputs. Replaces the fixed single-channel, pin-selected duty generator.
- Runs off the internal-oscillator clock and drives all motor outputs from one shared frame counter.
- Per-channel pulse widths are written through a simple write port and double-buffered, so width changes take effect only at frame boundaries and never glitch.
- Adds range clamping, an arm gate and a command-loss failsafe that forces all channels to the idle width.

---
 rtl/pwm_multi_if.sv | 28 ++
 rtl/pwm_multi.sv | 155 +++++++++++++++
 tb/tb_pwm_multi.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// ---------------------------------------------------------------------------
// pwm_multi_if
// Width-command write bus for pwm_multi.
//   wr_en    : one-cycle write strobe
//   wr_ch    : target channel index (CH_W bits)
//   wr_width : commanded pulse width in clocks (CNT_W bits)
// master drives the bus (controller / testbench), slave is the PWM block.
// ---------------------------------------------------------------------------
interface pwm_multi_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 17
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_width;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_width
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_width
    );
endinterface

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
// N-channel PWM generator for ESC/servo outputs sharing one frame counter.
// Widths are written into per-channel shadow registers (clamped to
// [MIN_W, MAX_W]) and copied to the active registers only at the frame
// boundary, so an output never changes width mid-frame. When disarmed or
// after FAILSAFE_FRAMES frames without a valid write, every channel is
// driven at IDLE_W.
//
// Ports:
//   i_osc_clk     : internal oscillator clock
//   i_rst_n       : asynchronous active-low reset
//   i_arm         : 1 = commanded widths, 0 = IDLE_W (sampled at boundary)
//   wr_if         : width write bus (slave modport)
//   o_pwm_out     : registered PWM outputs, one per channel
//   o_frame_start : one-cycle pulse while the frame counter is 0
//   o_failsafe    : command-loss status
// ---------------------------------------------------------------------------
module pwm_multi #(
    parameter int CHANNELS        = 4,
    parameter int CNT_W           = 17,
    parameter int PERIOD          = 106400,
    parameter int MIN_W           = 53200,
    parameter int MAX_W           = 103200,
    parameter int IDLE_W          = 33200,
    parameter int FAILSAFE_FRAMES = 50,
    parameter int CH_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_osc_clk,
    input  logic                i_rst_n,
    input  logic                i_arm,
    pwm_multi_if.slave          wr_if,
    output logic [CHANNELS-1:0] o_pwm_out,
    output logic                o_frame_start,
    output logic                o_failsafe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] W_MIN    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] W_MAX    = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] W_IDLE   = CNT_W'(IDLE_W);

    // Loss counter only needs to reach FAILSAFE_FRAMES before saturating.
    localparam int               LOSS_W    = (FAILSAFE_FRAMES > 0) ?
                                             $clog2(FAILSAFE_FRAMES + 1) : 1;
    localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(FAILSAFE_FRAMES);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(FAILSAFE_FRAMES - 1);

    logic [CNT_W-1:0]               r_cnt;
    logic                           r_frame_start;
    logic [LOSS_W-1:0]              r_loss;
    logic                           r_failsafe;
    logic [CHANNELS-1:0][CNT_W-1:0] r_shadow;
    logic [CHANNELS-1:0][CNT_W-1:0] r_active;
    logic [CHANNELS-1:0]            r_pwm;

    logic                           w_boundary;
    logic                           w_wr_valid;
    logic                           w_use_idle;
    logic [CNT_W-1:0]               w_clamped;

    // -----------------------------------------------------------------------
    // Combinational decode
    // -----------------------------------------------------------------------
    assign w_boundary = (r_cnt == CNT_LAST);

    // Out-of-range channel writes are dropped completely: they neither land
    // in a shadow nor count as command traffic for the failsafe.
    assign w_wr_valid = wr_if.wr_en && (int'(wr_if.wr_ch) < CHANNELS);

    // Registered failsafe (not the next-state) gates the transfer, so the
    // boundary on which failsafe rises still transfers the shadows.
    assign w_use_idle = r_failsafe || !i_arm;

    always_comb begin
        w_clamped = wr_if.wr_width;
        if (wr_if.wr_width < W_MIN) begin
            w_clamped = W_MIN;
        end else if (wr_if.wr_width > W_MAX) begin
            w_clamped = W_MAX;
        end
    end

    // -----------------------------------------------------------------------
    // Frame counter and frame_start
    // -----------------------------------------------------------------------
    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_boundary ? '0 : r_cnt + 1'b1;
            r_frame_start <= w_boundary;
        end
    end

    // -----------------------------------------------------------------------
    // Command-loss failsafe
    // A valid write wins over a boundary increment landing on the same clock.
    // Failsafe comes out of reset asserted: no command has been seen yet.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loss     <= '0;
            r_failsafe <= 1'b1;
        end else if (w_wr_valid) begin
            r_loss     <= '0;
            r_failsafe <= 1'b0;
        end else if (w_boundary && (r_loss != LOSS_MAX)) begin
            r_loss <= r_loss + 1'b1;
            if (r_loss == LOSS_LAST) begin
                r_failsafe <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel shadow / active / output
    // A write on the boundary clock updates the shadow while the active
    // register is loaded from the old shadow value in the same edge, so
    // that write waits for the following boundary.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_shadow[g] <= W_IDLE;
            end else if (w_wr_valid && (wr_if.wr_ch == CH_W'(g))) begin
                r_shadow[g] <= w_clamped;
            end
        end

        always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_active[g] <= W_IDLE;
            end else if (w_boundary) begin
                r_active[g] <= w_use_idle ? W_IDLE : r_shadow[g];
            end
        end

        // High for exactly active clocks per frame; 0 -> always low,
        // PERIOD -> always high since cnt never exceeds PERIOD-1.
        always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_pwm[g] <= 1'b0;
            end else begin
                r_pwm[g] <= (r_cnt < r_active[g]);
            end
        end
    end

    assign o_pwm_out     = r_pwm;
    assign o_frame_start = r_frame_start;
    assign o_failsafe    = r_failsafe;

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
// Directed bench for pwm_multi with CHANNELS=3 (so wr_ch=3 is out of range),
// PERIOD=100, MIN_W=20, MAX_W=80, IDLE_W=10, FAILSAFE_FRAMES=3.
// Frames are walked one at a time from a negedge where frame_start is high;
// per-channel high counts over the 100 samples give the width.
// ---------------------------------------------------------------------------
module tb_pwm_multi;
    localparam int CH  = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arm;
    logic [CH-1:0] pwm;
    logic          fs;
    logic          fsafe;

    int n_chk  = 0;
    int n_pass = 0;

    pwm_multi_if #(.CH_W(CHW), .CNT_W(CW)) wr_if ();

    pwm_multi #(
        .CHANNELS(CH), .CNT_W(CW), .PERIOD(100), .MIN_W(20), .MAX_W(80),
        .IDLE_W(10), .FAILSAFE_FRAMES(3)
    ) dut (
        .i_osc_clk    (clk),
        .i_rst_n      (rst_n),
        .i_arm        (arm),
        .wr_if        (wr_if.slave),
        .o_pwm_out    (pwm),
        .o_frame_start(fs),
        .o_failsafe   (fsafe)
    );

    always #5 clk = ~clk;

    // Bounded wait for frame_start, sampled on negedges.
    task automatic wait_fs(output int n);
        n = 0;
        while (fs !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (fs !== 1'b1) begin
            n_chk++;
            $display("FAIL wait_fs: frame_start not seen within %0d cycles", n);
        end
    endtask

    // Walk one frame (cnt 0..99). Writes wk0/wk1 land on the clock where
    // cnt==wk; arm is cleared on the clock where cnt==arm_k.
    task automatic run_frame(input int wk0, input int wch0, input int ww0,
                             input int wk1, input int wch1, input int ww1,
                             input int arm_k,
                             output int h0, output int h1, output int h2,
                             output int nfs, output logic fs_a, output logic fs_z);
        h0 = 0; h1 = 0; h2 = 0; nfs = 0; fs_a = 1'bx; fs_z = 1'bx;
        for (int k = 0; k < 100; k++) begin
            h0  += int'(pwm[0]);
            h1  += int'(pwm[1]);
            h2  += int'(pwm[2]);
            nfs += int'(fs);
            if (k == wk0 + 1) fs_a = fsafe;
            if (k == 99)      fs_z = fsafe;
            if (k == wk0) begin
                wr_if.wr_en = 1'b1; wr_if.wr_ch = CHW'(wch0); wr_if.wr_width = CW'(ww0);
            end else if (k == wk1) begin
                wr_if.wr_en = 1'b1; wr_if.wr_ch = CHW'(wch1); wr_if.wr_width = CW'(ww1);
            end else begin
                wr_if.wr_en = 1'b0;
            end
            if (k == arm_k) arm = 1'b0;
            @(negedge clk);
        end
        wr_if.wr_en = 1'b0;
    endtask

    int   h0, h1, h2, nfs, n;
    logic fs_a, fs_z;

    task automatic test_reset;
        rst_n = 1'b0; arm = 1'b0;
        wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_width = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (pwm !== 3'b000) $display("FAIL reset_pwm: got %b want 000", pwm); else n_pass++;
        n_chk++; if (fs !== 1'b0) $display("FAIL reset_fs: got %b want 0", fs); else n_pass++;
        n_chk++; if (fsafe !== 1'b1) $display("FAIL reset_failsafe: got %b want 1", fsafe); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_frames;
        wait_fs(n);
        n_chk++; if (n !== 100) $display("FAIL first_frame_start: got %0d cycles want 100", n); else n_pass++;
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 10 || h1 !== 10 || h2 !== 10)
            $display("FAIL idle_widths: got %0d %0d %0d want 10 10 10", h0, h1, h2); else n_pass++;
        n_chk++; if (nfs !== 1) $display("FAIL fs_per_frame: got %0d want 1", nfs); else n_pass++;
        n_chk++; if (fs !== 1'b1) $display("FAIL fs_period: got %b want 1 at cycle 100", fs); else n_pass++;
        n_chk++; if (fs_z !== 1'b1) $display("FAIL idle_failsafe: got %b want 1", fs_z); else n_pass++;
    endtask

    task automatic test_midframe_write;
        arm = 1'b1;
        run_frame(20, 0, 50, 21, 1, 5, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 10 || h1 !== 10 || h2 !== 10)
            $display("FAIL midframe_unchanged: got %0d %0d %0d want 10 10 10", h0, h1, h2); else n_pass++;
        n_chk++; if (fs_a !== 1'b0) $display("FAIL failsafe_clear: got %b want 0", fs_a); else n_pass++;
    endtask

    task automatic test_boundary_write;
        // ch2=200 mid-frame, ch1=60 on the cnt==99 clock
        run_frame(40, 2, 200, 99, 1, 60, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 50 || h1 !== 20 || h2 !== 10)
            $display("FAIL clamp_widths: got %0d %0d %0d want 50 20 10", h0, h1, h2); else n_pass++;
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 50 || h1 !== 20 || h2 !== 80)
            $display("FAIL boundary_write_held: got %0d %0d %0d want 50 20 80", h0, h1, h2); else n_pass++;
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 50 || h1 !== 60 || h2 !== 80)
            $display("FAIL boundary_write_late: got %0d %0d %0d want 50 60 80", h0, h1, h2); else n_pass++;
    endtask

    task automatic test_failsafe;
        // last write was on the boundary before frame D; this frame ends at the 3rd boundary
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 50 || h1 !== 60 || h2 !== 80)
            $display("FAIL pre_failsafe_widths: got %0d %0d %0d want 50 60 80", h0, h1, h2); else n_pass++;
        n_chk++; if (fs_z !== 1'b0) $display("FAIL failsafe_early: got %b want 0", fs_z); else n_pass++;
        n_chk++; if (fsafe !== 1'b1) $display("FAIL failsafe_rise: got %b want 1", fsafe); else n_pass++;
    endtask

    task automatic test_out_of_range;
        run_frame(50, 3, 30, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (fs_a !== 1'b1) $display("FAIL oor_keeps_failsafe: got %b want 1", fs_a); else n_pass++;
    endtask

    task automatic test_restore;
        run_frame(50, 0, 70, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 10 || h1 !== 10 || h2 !== 10)
            $display("FAIL failsafe_idle: got %0d %0d %0d want 10 10 10", h0, h1, h2); else n_pass++;
        n_chk++; if (fs_a !== 1'b0) $display("FAIL restore_clear: got %b want 0", fs_a); else n_pass++;
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 70 || h1 !== 60 || h2 !== 80)
            $display("FAIL restore_widths: got %0d %0d %0d want 70 60 80", h0, h1, h2); else n_pass++;
    endtask

    task automatic test_disarm_reset;
        run_frame(-1, 0, 0, -1, 0, 0, 30, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 70 || h1 !== 60 || h2 !== 80)
            $display("FAIL disarm_midframe: got %0d %0d %0d want 70 60 80", h0, h1, h2); else n_pass++;
        run_frame(-1, 0, 0, -1, 0, 0, -1, h0, h1, h2, nfs, fs_a, fs_z);
        n_chk++; if (h0 !== 10 || h1 !== 10 || h2 !== 10)
            $display("FAIL disarm_idle: got %0d %0d %0d want 10 10 10", h0, h1, h2); else n_pass++;
        n_chk++; if (nfs !== 1) $display("FAIL disarm_fs: got %0d want 1", nfs); else n_pass++;
        repeat (5) @(negedge clk);
        n_chk++; if (pwm !== 3'b111) $display("FAIL mid_pulse: got %b want 111", pwm); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (pwm !== 3'b000) $display("FAIL async_reset_pwm: got %b want 000", pwm); else n_pass++;
        n_chk++; if (fs !== 1'b0 || fsafe !== 1'b1)
            $display("FAIL async_reset_status: got fs=%b failsafe=%b want 0 1", fs, fsafe); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (pwm !== 3'b111) $display("FAIL restart_pulse: got %b want 111", pwm); else n_pass++;
        wait_fs(n);
        n_chk++; if (n !== 99) $display("FAIL restart_cnt: got %0d more cycles want 99", n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_frames();
        test_midframe_write();
        test_boundary_write();
        test_failsafe();
        test_out_of_range();
        test_restore();
        test_disarm_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
